uart_autobaud: RTL



---
 rtl/uart_autobaud.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures a 0x55 sync character on the raw RX line
// and hands a validated prescaler to the receiver while it is idle.
module uart_autobaud #(
  parameter int unsigned DEFAULT_PRESCALER = 25,
  parameter int unsigned MIN_PRESCALER     = 4,
  parameter int unsigned TIMEOUT           = 1048575,
  parameter int unsigned IDLE_CYCLES       = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        cfg_load,
  input  logic [15:0] cfg_prescaler,
  input  logic        rxd,
  input  logic        rx_busy,
  output logic [15:0] prescaler_config,
  output logic        busy,
  output logic        locked,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HIGH,
    S_WAIT_FALL,
    S_MEASURE,
    S_APPLY
  } state_t;

  localparam logic [19:0] TMO  = 20'(TIMEOUT);
  localparam logic [19:0] IDLC = 20'(IDLE_CYCLES);
  localparam logic [17:0] MINP = 18'(MIN_PRESCALER);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] hcnt_q, hcnt_d;
  logic [19:0] intv_q, intv_d;
  logic [19:0] low_q, low_d;
  logic [19:0] ref_q, ref_d;
  logic [1:0]  nrise_q, nrise_d;
  logic [2:0]  nfall_q, nfall_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] presc_q, presc_d;
  logic        from_meas_q, from_meas_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        fall, rise, tmo;
  logic [20:0] low2, intv_w, d_li;
  logic [19:0] d_ref;
  logic        ok_li, ok_ref, ok_all;
  logic [17:0] result;
  logic        res_ok;

  always_comb begin
    fall   = prev_q & ~sync2_q;
    rise   = ~prev_q & sync2_q;
    tmo    = (cnt_q == TMO);
    low2   = {low_q, 1'b0};
    intv_w = {1'b0, intv_q};
    d_li   = (low2 >= intv_w) ? low2 - intv_w
                              : intv_w - low2;
    ok_li  = d_li <= {3'b000, intv_q[19:2]};
    d_ref  = (intv_q >= ref_q) ? intv_q - ref_q
                               : ref_q - intv_q;
    // the reference interval is only known from the second fall on
    ok_ref = (nfall_q == 3'd0) ||
             (d_ref <= {2'b00, ref_q[19:2]});
    ok_all = (nrise_q == 2'd1) && ok_li && ok_ref;
    result = 18'((21'(cnt_q) + 21'd4) >> 3);
    res_ok = (result >= MINP) &&
             (result[17:16] == 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = rxd;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    intv_d      = intv_q;
    low_d       = low_q;
    ref_d       = ref_q;
    nrise_d     = nrise_q;
    nfall_d     = nfall_q;
    pend_d      = pend_q;
    presc_d     = presc_q;
    from_meas_d = from_meas_q;
    locked_d    = locked_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          pend_d      = cfg_prescaler;
          from_meas_d = 1'b0;
          locked_d    = 1'b0;
          state_d     = S_APPLY;
        end else if (start) begin
          locked_d = 1'b0;
          cnt_d    = 20'd1;
          hcnt_d   = 20'd0;
          state_d  = S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        cnt_d = cnt_q + 20'd1;
        if (tmo) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (sync2_q) begin
          hcnt_d = hcnt_q + 20'd1;
          if (hcnt_q + 20'd1 == IDLC) begin
            cnt_d   = 20'd1;
            state_d = S_WAIT_FALL;
          end
        end else begin
          hcnt_d = 20'd0;
        end
      end

      S_WAIT_FALL: begin
        cnt_d = cnt_q + 20'd1;
        if (tmo) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d   = 20'd1;
          intv_d  = 20'd1;
          low_d   = 20'd1;
          nrise_d = 2'd0;
          nfall_d = 3'd0;
          state_d = S_MEASURE;
        end
      end

      S_MEASURE: begin
        // cnt_q is the elapsed time since the first fall
        cnt_d  = cnt_q + 20'd1;
        intv_d = intv_q + 20'd1;
        low_d  = low_q + {19'd0, ~sync2_q};
        if (rise && nrise_q != 2'd3)
          nrise_d = nrise_q + 2'd1;
        if (tmo) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          if (!ok_all) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            nfall_d = nfall_q + 3'd1;
            if (nfall_q == 3'd0)
              ref_d = intv_q;
            intv_d  = 20'd1;
            low_d   = 20'd1;
            nrise_d = 2'd0;
            if (nfall_q == 3'd3) begin
              if (res_ok) begin
                pend_d      = result[15:0];
                from_meas_d = 1'b1;
                state_d     = S_APPLY;
              end else begin
                error_d = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end
      end

      S_APPLY: begin
        if (!rx_busy) begin
          presc_d  = pend_q;
          locked_d = from_meas_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      intv_q      <= '0;
      low_q       <= '0;
      ref_q       <= '0;
      nrise_q     <= '0;
      nfall_q     <= '0;
      pend_q      <= '0;
      presc_q     <= 16'(DEFAULT_PRESCALER);
      from_meas_q <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      intv_q      <= intv_d;
      low_q       <= low_d;
      ref_q       <= ref_d;
      nrise_q     <= nrise_d;
      nfall_q     <= nfall_d;
      pend_q      <= pend_d;
      presc_q     <= presc_d;
      from_meas_q <= from_meas_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign prescaler_config = presc_q;
  assign busy             = busy_q;
  assign locked           = locked_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule
